// File: rtl/mac_tx_scheduler.sv
// mac_tx_scheduler: one-hot MAC TX grant arbiter (arp_reply > arp_request/auto > icmp > udp) with IFG, grant watchdog and auto ARP retry; in: clk rst *_req arp_found mac_not_exist mac_send_end; out: *_gnt tx_busy tx_timeout arp_pending
module mac_tx_scheduler #(
  parameter int IFG_CYCLES       = 12,
  parameter int TX_TIMEOUT       = 4096,
  parameter int ARP_RETRY_CYCLES = 125000000
) (
  input  logic clk,
  input  logic rst,
  input  logic arp_reply_req,
  input  logic arp_request_req,
  input  logic icmp_tx_req,
  input  logic udp_tx_req,
  input  logic arp_found,
  input  logic mac_not_exist,
  input  logic mac_send_end,
  output logic arp_reply_gnt,
  output logic arp_request_gnt,
  output logic icmp_tx_gnt,
  output logic udp_tx_gnt,
  output logic tx_busy,
  output logic tx_timeout,
  output logic arp_pending
);
  localparam int WW = $clog2(TX_TIMEOUT) + 1;
  localparam int GW = $clog2(IFG_CYCLES) + 1;
  localparam int RW = $clog2(ARP_RETRY_CYCLES) + 1;
  localparam logic [WW-1:0] WD_MAX = WW'(TX_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(IFG_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(ARP_RETRY_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state_q, state_d;
  logic [3:0] gnt_q, gnt_d, win;
  logic [WW-1:0] wd_q, wd_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [RW-1:0] retry_q, retry_d;
  logic retry_run_q, retry_run_d, auto_q, auto_d, pend_q, pend_d, to_q, to_d;
  logic clr, auto_set, fire;
  assign clr      = arp_found | ~mac_not_exist;
  assign auto_set = (state_q == IDLE) & udp_tx_req & mac_not_exist & ~pend_q & ~arp_found;
  assign fire     = retry_run_q & (retry_q == RETRY_MAX);
  assign win = arp_reply_req                              ? 4'b0001 :
               (arp_request_req | auto_q | auto_set)      ? 4'b0010 :
               icmp_tx_req                                ? 4'b0100 :
               (udp_tx_req & ~mac_not_exist)              ? 4'b1000 : 4'b0000;
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    wd_d        = wd_q;
    gap_d       = gap_q;
    retry_d     = retry_q;
    retry_run_d = retry_run_q;
    auto_d      = auto_q;
    pend_d      = pend_q;
    to_d        = 1'b0;
    if (retry_run_q) begin
      if (fire) retry_run_d = 1'b0;
      else retry_d = retry_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (auto_set) begin
          pend_d = 1'b1;
          auto_d = 1'b1;
        end
        if (|win) begin
          state_d = SEND;
          gnt_d   = win;
          wd_d    = '0;
          if (win[1]) auto_d = 1'b0;
        end
      end
      SEND: begin
        if (mac_send_end | (wd_q == WD_MAX)) begin
          state_d = GAP;
          gnt_d   = '0;
          gap_d   = '0;
          to_d    = ~mac_send_end;
          if (gnt_q[1] & pend_q) begin
            retry_run_d = 1'b1;
            retry_d     = '0;
          end
        end else wd_d = wd_q + 1'b1;
      end
      GAP: begin
        if (gap_q == GAP_MAX) state_d = IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (fire) auto_d = 1'b1;
    if (clr) begin
      pend_d      = 1'b0;
      auto_d      = 1'b0;
      retry_run_d = 1'b0;
      retry_d     = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      wd_q        <= '0;
      gap_q       <= '0;
      retry_q     <= '0;
      retry_run_q <= 1'b0;
      auto_q      <= 1'b0;
      pend_q      <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
      retry_q     <= retry_d;
      retry_run_q <= retry_run_d;
      auto_q      <= auto_d;
      pend_q      <= pend_d;
      to_q        <= to_d;
    end
  end
  assign arp_reply_gnt   = gnt_q[0];
  assign arp_request_gnt = gnt_q[1];
  assign icmp_tx_gnt     = gnt_q[2];
  assign udp_tx_gnt      = gnt_q[3];
  assign tx_busy         = state_q != IDLE;
  assign tx_timeout      = to_q;
  assign arp_pending     = pend_q;
endmodule

// File: doc/mac_tx_scheduler.md
Name: mac_tx_scheduler

Overview:
- Schedules the single MAC transmit path among four frame sources: ARP reply, ARP request, ICMP echo reply and UDP video payload.
- Grants exactly one source at a time, holds the grant until the MAC reports frame end, then enforces an inter-frame gap.
- Automatically issues and retries ARP requests while the destination MAC is unresolved, and blocks UDP until resolution.
- Sits between the requesters and the MAC TX top in the gmii_tx_clk domain.

Parameters:
- IFG_CYCLES, 12, idle cycles between a frame end and the next grant (≥1).
- TX_TIMEOUT, 4096, max cycles a grant may be held without mac_send_end.
- ARP_RETRY_CYCLES, 125000000, cycles between automatic ARP request retries (1 s at 125 MHz).

Ports:
- clk  in  1  gmii_tx_clk domain clock.
- rst  in  1  asynchronous, active-high reset.
- arp_reply_req  in  1  level; ARP reply pending.
- arp_request_req  in  1  level; user/manual ARP request.
- icmp_tx_req  in  1  level; ICMP reply frame ready.
- udp_tx_req  in  1  level; UDP payload ready (FIFO threshold reached).
- arp_found  in  1  pulse; ARP reply for destination IP received.
- mac_not_exist  in  1  level; destination MAC not in cache.
- mac_send_end  in  1  pulse; MAC finished current frame.
- arp_reply_gnt  out  1  grant, level.
- arp_request_gnt  out  1  grant, level.
- icmp_tx_gnt  out  1  grant, level.
- udp_tx_gnt  out  1  grant, level.
- tx_busy  out  1  high in SEND or GAP.
- tx_timeout  out  1  one-cycle pulse on grant watchdog expiry.
- arp_pending  out  1  automatic ARP resolution in progress.

Behaviour:
- Reset: all grants 0, tx_busy 0, tx_timeout 0, arp_pending 0, FSM IDLE, all counters 0. Reset mid-frame drops the grant immediately (async).
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - Evaluate requests each cycle with fixed priority: arp_reply > arp_request (manual OR auto) > icmp > udp.
  - udp is eligible only when mac_not_exist = 0.
  - The winner's grant rises the next cycle (1-cycle latency), and the FSM enters SEND. Grants are one-hot or zero at all times.
- SEND:
  - Grant held regardless of the requester dropping req.
  - Watchdog counts from 0.
  - mac_send_end → grant falls next cycle → GAP.
  - Watchdog reaching TX_TIMEOUT-1 without mac_send_end → grant falls, tx_timeout pulses 1 cycle → GAP.
  - mac_send_end in the expiry cycle counts as a normal end; no tx_timeout pulse.
  - mac_send_end outside SEND is ignored.
- GAP:
  - Exactly IFG_CYCLES cycles with no grant, then IDLE.
  - Requests arriving in GAP wait; no queuing of pulses, because requests are levels.
- Auto ARP:
  - In IDLE, if udp_tx_req = 1, mac_not_exist = 1 and arp_pending = 0: set arp_pending and raise an internal auto request (ARP request priority slot).
  - When that request's frame ends, start the retry counter. On reaching ARP_RETRY_CYCLES with mac_not_exist still 1, re-raise the auto request. Retries are unbounded.
  - arp_found, or mac_not_exist falling, clears arp_pending, the auto request and the retry counter in any state. It does not affect the current grant.
  - A manual and an auto request pending together produce one ARP request frame, and both are cleared by it.
- tx_busy = (state != IDLE).
- Counter widths: $clog2 of the respective parameter, +1. Counters saturate and never wrap.

Test Plan:
- Sim params IFG_CYCLES=12, TX_TIMEOUT=50, ARP_RETRY_CYCLES=100.
- Single ICMP: icmp_tx_req at cycle 10, mac_send_end at 40 → icmp_tx_gnt 1 during cycles 11–40, 0 at 41; tx_busy low at cycle 53; no other grant.
- Simultaneous requests: arp_reply, icmp and udp high at cycle 5 (mac_not_exist=0), each frame 20 cycles → grant order arp_reply, icmp, udp, each separated by 12 idle cycles; never two grants high.
- Unresolved MAC: udp_tx_req high, mac_not_exist=1 → arp_pending=1, arp_request_gnt issued, no udp_tx_gnt. Without arp_found, a second ARP grant occurs 100 cycles after the first frame end. Drop mac_not_exist and pulse arp_found → arp_pending=0, udp_tx_gnt follows after IFG.
- Watchdog: grant udp, withhold mac_send_end → grant drops after 50 cycles, tx_timeout one-cycle pulse, then 12-cycle gap. Repeat with mac_send_end exactly on cycle 50 → no tx_timeout pulse.
- Reset mid-SEND: assert rst during udp_tx_gnt → all outputs 0 asynchronously. After release with udp_tx_req still high → fresh grant 1 cycle after the first IDLE evaluation.
